// File: rtl/pwl_sweep_reader.sv
// Sweep engine for a single pwl evaluator: issues every time code once and streams
// the (t, v) results out on a valid/ready port, with credit-limited issue so no result is lost.
module pwl_sweep_reader #(
    parameter int unsigned IN_WIDTH      = 32,
    parameter int unsigned OUT_WIDTH     = 18,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned SEGMENT_WIDTH = 2,
    parameter int unsigned ADDR_OFFSET   = 0,
    parameter int unsigned PWL_LATENCY   = 1,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [IN_WIDTH-1:0]  pwl_in,
    input  logic [OUT_WIDTH-1:0] pwl_out,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [IN_WIDTH-1:0]  m_t,
    output logic [OUT_WIDTH-1:0] m_v,
    output logic                 m_last
);

    localparam int unsigned SWEEP_W = ADDR_WIDTH + SEGMENT_WIDTH + 1;
    localparam int unsigned N       = 1 << (ADDR_WIDTH + SEGMENT_WIDTH);
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned FLY_W   = $clog2(PWL_LATENCY + 1);
    localparam int unsigned CRED_W  = CNT_W + FLY_W;
    localparam int unsigned LAST    = PWL_LATENCY - 1;

    typedef struct packed {
        logic [IN_WIDTH-1:0]  t;
        logic [OUT_WIDTH-1:0] v;
        logic                 last;
    } beat_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state;
    logic [SWEEP_W-1:0]    issued;
    logic                  pipe_vld  [PWL_LATENCY];
    logic [IN_WIDTH-1:0]   pipe_t    [PWL_LATENCY];
    logic                  pipe_last [PWL_LATENCY];
    logic [FLY_W-1:0]      inflight;

    beat_t                 mem [FIFO_DEPTH];
    beat_t                 head;
    beat_t                 push_beat;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      rd_nxt;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      cnt_after_pop;

    logic                  issue;
    logic                  last_issue;
    logic                  push;
    logic                  pop;
    logic [CRED_W-1:0]     credit_used;

    // Issue/capture/handshake decisions; a beat leaving this cycle frees its slot for issue
    always_comb begin
        pop           = m_valid && m_ready;
        push          = pipe_vld[LAST];
        push_beat     = {pipe_t[LAST], pwl_out, pipe_last[LAST]};
        last_issue    = (issued == SWEEP_W'(N - 1));
        credit_used   = CRED_W'(fifo_count) + CRED_W'(inflight) - CRED_W'(pop);
        rd_nxt        = rd_ptr + PTR_W'(pop);
        cnt_after_pop = fifo_count - CNT_W'(pop);
        issue         = 1'b0;
        if (state == IDLE) begin
            issue = start;
        end else if (state == RUN) begin
            issue = (credit_used < CRED_W'(FIFO_DEPTH));
        end
    end

    assign m_t    = head.t;
    assign m_v    = head.v;
    assign m_last = head.last;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_beat;
        end
    end

    // Control FSM, in-flight pipe, FIFO pointers and registered output head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pwl_in     <= IN_WIDTH'(ADDR_OFFSET);
            issued     <= '0;
            inflight   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            m_valid    <= 1'b0;
            head       <= '0;
            for (int unsigned i = 0; i < PWL_LATENCY; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_t[i]    <= '0;
                pipe_last[i] <= 1'b0;
            end
        end else begin
            pipe_vld[0]  <= issue;
            pipe_t[0]    <= pwl_in;
            pipe_last[0] <= last_issue;
            for (int unsigned i = 1; i < PWL_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_t[i]    <= pipe_t[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end

            if (issue) begin
                pwl_in <= pwl_in + IN_WIDTH'(1);
                issued <= issued + SWEEP_W'(1);
            end
            inflight <= inflight + FLY_W'(issue) - FLY_W'(push);

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr     <= rd_nxt;
            fifo_count <= cnt_after_pop + CNT_W'(push);
            m_valid    <= (cnt_after_pop != '0) || push;
            // Head register tracks the oldest entry; it bypasses the memory when the FIFO runs empty
            if (cnt_after_pop != '0) begin
                head <= mem[rd_nxt];
            end else if (push) begin
                head <= push_beat;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= last_issue ? DRAIN : RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue && last_issue) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done   <= 1'b0;
                    pwl_in <= IN_WIDTH'(ADDR_OFFSET);
                    issued <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_pwl_sweep_reader.sv
// Directed bench for pwl_sweep_reader: two instances (L=1 at t=0, L=3 at t=100), each
// driven by a stub pwl computing v = 3*t with the matching latency.
module tb_pwl_sweep_reader;

    localparam int unsigned NB    = 16;
    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        start_a, ready_a, start_b, ready_b;
    logic        busy_a, done_a, valid_a, last_a;
    logic        busy_b, done_b, valid_b, last_b;
    logic [31:0] pwl_in_a, t_a, pwl_in_b, t_b;
    logic [17:0] pwl_out_a, v_a, pwl_out_b, v_b;
    logic [17:0] sb1, sb2;

    int n_chk  = 0;
    int n_fail = 0;

    pwl_sweep_reader #(
        .IN_WIDTH(32), .OUT_WIDTH(18), .ADDR_WIDTH(2), .SEGMENT_WIDTH(2),
        .ADDR_OFFSET(0), .PWL_LATENCY(1), .FIFO_DEPTH(DEPTH)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .pwl_in(pwl_in_a), .pwl_out(pwl_out_a), .m_valid(valid_a), .m_ready(ready_a),
        .m_t(t_a), .m_v(v_a), .m_last(last_a)
    );

    pwl_sweep_reader #(
        .IN_WIDTH(32), .OUT_WIDTH(18), .ADDR_WIDTH(2), .SEGMENT_WIDTH(2),
        .ADDR_OFFSET(100), .PWL_LATENCY(3), .FIFO_DEPTH(DEPTH)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .pwl_in(pwl_in_b), .pwl_out(pwl_out_b), .m_valid(valid_b), .m_ready(ready_b),
        .m_t(t_b), .m_v(v_b), .m_last(last_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub pwl evaluators, latency 1 and 3
    always @(posedge clk) pwl_out_a <= 18'(pwl_in_a * 32'd3);
    always @(posedge clk) begin
        sb1       <= 18'(pwl_in_b * 32'd3);
        sb2       <= sb1;
        pwl_out_b <= sb2;
    end

    typedef struct {
        logic        valid;
        logic        last;
        logic        busy;
        logic        done;
        logic [31:0] t;
        logic [17:0] v;
        logic [31:0] pwl_in;
    } obs_t;

    // mode: 0 ready=1, 1 random ready, 2 ready low for 20 cycles, 3 ready=1 plus second start
    typedef struct {
        int sel;
        int mode;
        int t0;
        int lat;
    } case_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic rd);
        if (sel == 0) begin
            start_a = st;
            ready_a = rd;
        end else begin
            start_b = st;
            ready_b = rd;
        end
    endtask

    task automatic snap(input int sel, output obs_t o);
        if (sel == 0) begin
            o.valid = valid_a; o.last = last_a; o.busy = busy_a; o.done = done_a;
            o.t = t_a; o.v = v_a; o.pwl_in = pwl_in_a;
        end else begin
            o.valid = valid_b; o.last = last_b; o.busy = busy_b; o.done = done_b;
            o.t = t_b; o.v = v_b; o.pwl_in = pwl_in_b;
        end
    endtask

    task automatic run_case(input case_t c);
        obs_t        o;
        obs_t        prev;
        logic        rdy;
        logic        st;
        logic        prev_stall = 1'b0;
        logic [31:0] et;
        int k = 0, first = -1, last_cyc = -1, dones = 0, done_cyc = -1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            st  = (cyc == 0) || (c.mode == 3 && cyc == 5);
            rdy = (c.mode == 1) ? 1'($urandom_range(0, 1)) :
                  (c.mode == 2) ? (cyc > 20) : 1'b1;
            drive(c.sel, st, rdy);
            snap(c.sel, o);
            if (cyc > 0) begin
                if (o.done) begin
                    dones++;
                    done_cyc = cyc;
                end
                if (o.valid && first < 0) begin
                    first = cyc;
                    chk("first_beat_latency", 64'(cyc), 64'(c.lat));
                end
                if (prev_stall)
                    chk("stall_hold", {o.valid, o.t, o.v, o.last},
                        {1'b1, prev.t, prev.v, prev.last});
                if ((c.mode == 0 || c.mode == 3) && first >= 0 && k < int'(NB))
                    chk("no_gap", 64'(o.valid), 64'd1);
                if (c.mode == 2 && cyc == 20) begin
                    chk("stall_issue_stop", 64'(o.pwl_in), 64'(c.t0 + int'(DEPTH)));
                    chk("stall_no_beats", 64'(k), 64'd0);
                end
                if (o.valid && rdy) begin
                    et = 32'(c.t0 + k);
                    chk("beat_t", 64'(o.t), 64'(et));
                    chk("beat_v", 64'(o.v), 64'(18'(et * 32'd3)));
                    chk("beat_last", 64'(o.last), 64'(k == int'(NB) - 1));
                    k++;
                    if (k == int'(NB)) last_cyc = cyc;
                end
                prev_stall = o.valid && !rdy;
                prev       = o;
            end
            if (last_cyc >= 0 && cyc >= last_cyc + 4) break;
        end
        chk("beat_count", 64'(k), 64'(NB));
        chk("done_pulses", 64'(dones), 64'd1);
        chk("done_timing", 64'(done_cyc), 64'(last_cyc + 1));
        drive(c.sel, 1'b0, 1'b0);
        snap(c.sel, o);
        chk("idle_busy", 64'(o.busy), 64'd0);
        chk("idle_valid", 64'(o.valid), 64'd0);
    endtask

    initial begin
        case_t cases [5];
        obs_t  o;
        int    k;

        cases[0] = '{sel: 0, mode: 0, t0: 0,   lat: 2};
        cases[1] = '{sel: 1, mode: 0, t0: 100, lat: 4};
        cases[2] = '{sel: 1, mode: 1, t0: 100, lat: 4};
        cases[3] = '{sel: 0, mode: 2, t0: 0,   lat: 2};
        cases[4] = '{sel: 0, mode: 3, t0: 0,   lat: 2};

        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            snap(s, o);
            chk("reset_busy", 64'(o.busy), 64'd0);
            chk("reset_done", 64'(o.done), 64'd0);
            chk("reset_valid", 64'(o.valid), 64'd0);
            chk("reset_last", 64'(o.last), 64'd0);
            chk("reset_pwl_in", 64'(o.pwl_in), (s == 0) ? 64'd0 : 64'd100);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_case(cases[i]);
            repeat (3) @(negedge clk);
        end

        // Reset asserted mid-sweep after the 7th beat, then a fresh sweep
        k = 0;
        @(negedge clk);
        drive(0, 1'b1, 1'b1);
        for (int c = 0; c < 100 && k < 7; c++) begin
            @(negedge clk);
            drive(0, 1'b0, 1'b1);
            if (valid_a) k++;
        end
        chk("abort_beats_seen", 64'(k), 64'd7);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        snap(0, o);
        chk("abort_busy", 64'(o.busy), 64'd0);
        chk("abort_valid", 64'(o.valid), 64'd0);
        chk("abort_last", 64'(o.last), 64'd0);
        chk("abort_pwl_in", 64'(o.pwl_in), 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            snap(0, o);
            chk("abort_no_done", 64'({o.done, o.valid}), 64'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        snap(0, o);
        chk("abort_idle_done", 64'(o.done), 64'd0);
        run_case(cases[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
